// File: rtl/rr_grant_arbiter.sv
// Registered round-robin arbiter: rotating-priority winner selection presented
// through a valid/ready handshake, grant frozen until accepted.
module rr_grant_arbiter #(
    parameter  int unsigned Count     = 4,
    localparam int unsigned CountBits = $clog2(Count)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [Count-1:0]     requests,
    output logic                 grant_valid,
    input  logic                 grant_ready,
    output logic [CountBits-1:0] grant_index,
    output logic [Count-1:0]     grant_onehot
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t               r_state;
    state_t               w_state_next;
    logic [CountBits-1:0] r_ptr;
    logic [CountBits-1:0] w_ptr_next;
    logic [CountBits-1:0] r_idx;
    logic [CountBits-1:0] w_idx_next;
    logic [Count-1:0]     r_onehot;
    logic [Count-1:0]     w_onehot_next;

    logic [Count-1:0]     w_high;
    logic [Count-1:0]     w_pick;
    logic [CountBits-1:0] w_winner;

    // Requests at or above the pointer take priority; otherwise wrap to the lowest request.
    always_comb begin
        w_high   = '0;
        w_winner = '0;
        for (int i = 0; i < int'(Count); i++) begin
            w_high[i] = requests[i] && (CountBits'(i) >= r_ptr);
        end
        w_pick = (|w_high) ? w_high : requests;
        for (int i = int'(Count) - 1; i >= 0; i--) begin
            if (w_pick[i]) begin
                w_winner = CountBits'(i);
            end
        end
    end

    always_comb begin
        w_state_next  = r_state;
        w_ptr_next    = r_ptr;
        w_idx_next    = r_idx;
        w_onehot_next = r_onehot;
        case (r_state)
            IDLE: begin
                if (|requests) begin
                    w_state_next  = GRANT;
                    w_idx_next    = w_winner;
                    w_onehot_next = Count'(1) << w_winner;
                end
            end
            GRANT: begin
                if (grant_ready) begin
                    w_state_next  = IDLE;
                    w_onehot_next = '0;
                    w_ptr_next    = (r_idx == CountBits'(Count - 1)) ? '0 : r_idx + CountBits'(1);
                end
            end
            default: begin
                w_state_next  = IDLE;
                w_onehot_next = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= IDLE;
            r_ptr    <= '0;
            r_idx    <= '0;
            r_onehot <= '0;
        end else begin
            r_state  <= w_state_next;
            r_ptr    <= w_ptr_next;
            r_idx    <= w_idx_next;
            r_onehot <= w_onehot_next;
        end
    end

    assign grant_valid  = (r_state == GRANT);
    assign grant_index  = r_idx;
    assign grant_onehot = r_onehot;

endmodule

// File: tb/tb_rr_grant_arbiter.sv
// Bench for rr_grant_arbiter: directed vector table, hand-written corner sequences
// and randomized traffic against a circular-scan reference model (Count=4 and 5).
module tb_rr_grant_arbiter;

    logic       clk;
    logic       reset;
    logic [3:0] requests;
    logic       grant_ready;
    logic       grant_valid;
    logic [1:0] grant_index;
    logic [3:0] grant_onehot;

    logic [4:0] requests5;
    logic       ready5;
    logic       valid5;
    logic [2:0] index5;
    logic [4:0] onehot5;

    int n_pass;
    int n_total;

    rr_grant_arbiter #(.Count(4)) dut (
        .clk         (clk),
        .reset       (reset),
        .requests    (requests),
        .grant_valid (grant_valid),
        .grant_ready (grant_ready),
        .grant_index (grant_index),
        .grant_onehot(grant_onehot)
    );

    rr_grant_arbiter #(.Count(5)) dut5 (
        .clk         (clk),
        .reset       (reset),
        .requests    (requests5),
        .grant_valid (valid5),
        .grant_ready (ready5),
        .grant_index (index5),
        .grant_onehot(onehot5)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] req;
        logic       rdy;
        logic       exp_valid;
        int         exp_index;
        logic [3:0] exp_onehot;
    } vec_t;

    typedef struct {
        int ptr;
        int win;
        bit busy;
    } mstate_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic [3:0] req, input logic rdy, input logic v,
                       input int idx, input logic [3:0] oh);
        vec_t e;
        e.req = req; e.rdy = rdy; e.exp_valid = v; e.exp_index = idx; e.exp_onehot = oh;
        vecs.push_back(e);
    endtask

    task automatic do_reset();
        requests = '0; grant_ready = 0; requests5 = '0; ready5 = 0;
        #1 reset = 1;
        step();
        reset = 0;
    endtask

    // Reference: scan circularly from ptr for the first requester; ptr moves past an accepted winner.
    function automatic mstate_t model_step(mstate_t s, int n, logic [31:0] req, bit rdy);
        mstate_t r = s;
        if (s.busy) begin
            if (rdy) begin
                r.ptr  = (s.win + 1) % n;
                r.busy = 0;
            end
        end else if (req != 0) begin
            for (int k = 0; k < n; k++) begin
                int j = (s.ptr + k) % n;
                if (!r.busy && req[j]) begin
                    r.win  = j;
                    r.busy = 1;
                end
            end
        end
        return r;
    endfunction

    initial begin
        mstate_t m4;
        mstate_t m5;
        logic [31:0] exp_oh;
        clk = 0; reset = 0; n_pass = 0; n_total = 0;
        requests = '0; grant_ready = 0; requests5 = '0; ready5 = 0;

        // Sparse rotation, fairness, then backpressure/hold
        for (int i = 0; i < 2; i++) begin
            add(4'b1010, 1, 1, 1, 4'b0010); add(4'b1010, 1, 0, 0, 4'b0000);
            add(4'b1010, 1, 1, 3, 4'b1000); add(4'b1010, 1, 0, 0, 4'b0000);
        end
        for (int i = 0; i < 6; i++) begin
            add(4'b1111, 1, 1, i % 4, 4'b0001 << (i % 4));
            add(4'b1111, 1, 0, 0, 4'b0000);
        end
        add(4'b0100, 0, 1, 2, 4'b0100); add(4'b0100, 0, 1, 2, 4'b0100);
        add(4'b0000, 0, 1, 2, 4'b0100); add(4'b0000, 0, 1, 2, 4'b0100);
        add(4'b0000, 0, 1, 2, 4'b0100); add(4'b0000, 1, 0, 0, 4'b0000);
        add(4'b0000, 0, 0, 0, 4'b0000); add(4'b1111, 0, 1, 3, 4'b1000);
        add(4'b1111, 1, 0, 0, 4'b0000); add(4'b0000, 0, 0, 0, 4'b0000);

        // Reset asserted with requests present and no clock edge
        #1 reset = 1;
        requests = 4'b1111;
        #2;
        check("rst_valid", 32'(grant_valid), 32'd0);
        check("rst_index", 32'(grant_index), 32'd0);
        check("rst_onehot", 32'(grant_onehot), 32'd0);
        step();
        reset = 0; grant_ready = 1;
        step();
        check("first_valid", 32'(grant_valid), 32'd1);
        check("first_index", 32'(grant_index), 32'd0);

        do_reset();
        foreach (vecs[i]) begin
            requests = vecs[i].req;
            grant_ready = vecs[i].rdy;
            step();
            check($sformatf("vec%0d_valid", i), 32'(grant_valid), 32'(vecs[i].exp_valid));
            if (vecs[i].exp_valid)
                check($sformatf("vec%0d_index", i), 32'(grant_index), 32'(vecs[i].exp_index));
            check($sformatf("vec%0d_onehot", i), 32'(grant_onehot), 32'(vecs[i].exp_onehot));
        end

        // Wrap on Count=5: ptr after index 4 must return to 0
        do_reset();
        requests5 = 5'b10000; ready5 = 1;
        step();
        check("wrap_idx4", 32'(index5), 32'd4);
        check("wrap_oh4", 32'(onehot5), 32'h10);
        step();
        check("wrap_hs_valid", 32'(valid5), 32'd0);
        requests5 = 5'b10001;
        step();
        check("wrap_valid", 32'(valid5), 32'd1);
        check("wrap_idx0", 32'(index5), 32'd0);
        requests5 = 5'b10010;
        step();
        step();
        check("wrap_idx1", 32'(index5), 32'd1);

        // Asynchronous reset pulse in the middle of a held grant
        do_reset();
        requests = 4'b0100; grant_ready = 0;
        step();
        step();
        check("hold_idx2", 32'(grant_index), 32'd2);
        #2 reset = 1;
        #1;
        check("async_valid", 32'(grant_valid), 32'd0);
        check("async_onehot", 32'(grant_onehot), 32'd0);
        #1 reset = 0;
        requests = 4'b1111; grant_ready = 1;
        step();
        check("post_rst_valid", 32'(grant_valid), 32'd1);
        check("post_rst_idx", 32'(grant_index), 32'd0);

        // Random traffic on both instances against the reference model
        do_reset();
        m4 = '{ptr: 0, win: 0, busy: 0};
        m5 = '{ptr: 0, win: 0, busy: 0};
        for (int c = 0; c < 400; c++) begin
            requests    = ($urandom_range(0, 3) == 0) ? 4'b0 : 4'($urandom);
            grant_ready = ($urandom_range(0, 2) != 0);
            requests5   = ($urandom_range(0, 3) == 0) ? 5'b0 : 5'($urandom);
            ready5      = ($urandom_range(0, 2) != 0);
            m4 = model_step(m4, 4, 32'(requests), grant_ready);
            m5 = model_step(m5, 5, 32'(requests5), ready5);
            step();
            check($sformatf("rnd4_valid_c%0d", c), 32'(grant_valid), 32'(m4.busy));
            exp_oh = m4.busy ? (32'd1 << m4.win) : 32'd0;
            check($sformatf("rnd4_onehot_c%0d", c), 32'(grant_onehot), exp_oh);
            if (m4.busy) check($sformatf("rnd4_index_c%0d", c), 32'(grant_index), 32'(m4.win));
            check($sformatf("rnd5_valid_c%0d", c), 32'(valid5), 32'(m5.busy));
            exp_oh = m5.busy ? (32'd1 << m5.win) : 32'd0;
            check($sformatf("rnd5_onehot_c%0d", c), 32'(onehot5), exp_oh);
            if (m5.busy) check($sformatf("rnd5_index_c%0d", c), 32'(index5), 32'(m5.win));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
